ctl_trigger: RTL and testbench
==============================

// Module: ctl_trigger
// PURPOSE
//  Upstream stage of the ammo counter. Conditions the raw light-gun trigger (pin, asynchronous, bouncy) into one
//  clean shot_fired pulse per pull. Enforces flash window and re-fire cooldown; refuses to fire when no_ammo.
//  Feeds shot_fired to the ammo counter, shot_flash to hit detection / screen-flash renderer.
// PARAMETERS
//  DEBOUNCE_CYCLES  650_000     consecutive stable synced samples needed to change debounced level (10 ms @ 65 MHz)
//  FLASH_CYCLES     1_083_333   shot_flash high time in cycles, incl. shot_fired cycle (~1 VGA frame @ 65 MHz)
//  COOLDOWN_CYCLES  16_250_000  dead time after flash before next shot may be accepted (250 ms)
// PORTS
//  clk           in   1  system clock; single clock domain
//  rst           in   1  synchronous, active-high reset; clears everything incl. debouncer
//  reset_score   in   1  synchronous, active-high game restart; clears FSM/outputs only, debouncer keeps state
//  trigger_raw   in   1  raw trigger pin, 1 = pulled; asynchronous to clk
//  no_ammo       in   1  from ammo counter; 1 = magazine empty
//  shot_fired    out  1  one-cycle pulse, one per accepted pull
//  shot_flash    out  1  high for FLASH_CYCLES starting with the shot_fired cycle
//  click_empty   out  1  one-cycle pulse: pull accepted by debouncer while no_ammo=1 (dry-fire sound)
//  trigger_ready out  1  1 only in IDLE (gun may fire)
// BEHAVIOUR
//  - All outputs registered; reset value 0 for every output (rst or reset_score).
//  - Sync: 2-FF synchronizer on trigger_raw; sync FFs cleared by rst only.
//  - Debounce: counter runs while synced level != debounced level, clears when equal; debounced level flips on the
//    edge where counter would reach DEBOUNCE_CYCLES. Glitch shorter than DEBOUNCE_CYCLES -> no change. rst clears to 0.
//  - Latency: raw high first sampled at edge 0 -> debounced high after edge DEBOUNCE_CYCLES+1 -> shot_fired high
//    between edges DEBOUNCE_CYCLES+2 and DEBOUNCE_CYCLES+3.
//  - FSM states: WAIT_RELEASE, IDLE, FLASH, COOLDOWN. Reset state WAIT_RELEASE.
//    WAIT_RELEASE: debounced==0 -> IDLE (prevents firing on a trigger held through reset/restart).
//    IDLE: trigger_ready=1. debounced==1 & no_ammo==0 -> FLASH, pulse shot_fired, load flash counter.
//          debounced==1 & no_ammo==1 -> WAIT_RELEASE, pulse click_empty; no shot_fired.
//    FLASH: shot_flash=1; after FLASH_CYCLES total flash cycles -> COOLDOWN, load cooldown counter.
//    COOLDOWN: all outputs 0; after COOLDOWN_CYCLES -> WAIT_RELEASE (trigger must be released to re-arm).
//  - Pulls during FLASH/COOLDOWN ignored, never queued. no_ammo sampled only in IDLE.
//  - no_ammo rising during FLASH does not cut flash short.
//  - reset_score mid-FLASH/COOLDOWN: next cycle state WAIT_RELEASE, outputs 0, timers cleared.
//  - rst and reset_score together: rst semantics.
//  - One shared down-counter, width $clog2(max(FLASH_CYCLES,COOLDOWN_CYCLES)+1); no wrap; loads on state entry.
//  - Params must be >=1; FLASH_CYCLES=1 -> shot_flash coincides with shot_fired only.
// STRUCTURE
//  - ctl_pkg: trigger_state_t enum {WAIT_RELEASE, IDLE, FLASH, COOLDOWN}; default timing localparams (CLK_HZ=65_000_000,
//    DEBOUNCE/FLASH/COOLDOWN defaults) shared with ammo/score blocks.
//  - Sub-module ctl_debounce (synchronizer + stability counter, param DEBOUNCE_CYCLES; in clk, rst, sig_raw;
//    out sig_db). Top holds FSM, timer, output regs.
// TESTING (bench params DEBOUNCE_CYCLES=4, FLASH_CYCLES=3, COOLDOWN_CYCLES=8)
//  1 rst, raw=1 held 20 cycles, no_ammo=0 -> shot_fired 1-cycle pulse after edge 6; shot_flash high 3 cycles; exactly one shot.
//  2 raw bounce 1,0,1,0 each 2 cycles, then stable 1 -> no debounced change during bounce; single shot after stable run.
//  3 pull, release after flash, re-pull during COOLDOWN -> ignored; re-pull after WAIT_RELEASE->IDLE -> second shot.
//  4 no_ammo=1, pull -> click_empty 1 pulse, shot_fired/shot_flash stay 0; hold -> no repeat click until release.
//  5 reset_score asserted in FLASH cycle 2 with trigger held -> outputs 0 next cycle; no shot until release + new pull.
//  6 loop with ctl_ammo (16 rounds): 17 clean pulls -> 16 shot_fired, ammo 0, 17th pull yields click_empty.

Source files
------------

// File: rtl/ctl_pkg.sv
// ctl_pkg: shared trigger FSM states and default timing for the light-gun control blocks
package ctl_pkg;
    typedef enum logic [1:0] {WAIT_RELEASE, IDLE, FLASH, COOLDOWN} trigger_state_t;
    localparam int CLK_HZ               = 65_000_000;
    localparam int DEBOUNCE_CYCLES_DEF  = 650_000;
    localparam int FLASH_CYCLES_DEF     = 1_083_333;
    localparam int COOLDOWN_CYCLES_DEF  = 16_250_000;
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/ctl_debounce.sv
// ctl_debounce: 2-FF synchronizer followed by a stability counter that only accepts long-lived level changes
module ctl_debounce
    import ctl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_raw,
    output logic sig_db
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          diff, hit;
    // Count consecutive disagreeing samples; flip the level on the edge the count would reach the threshold
    always_comb begin
        diff  = sync_q[1] != db_q;
        hit   = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
        cnt_d = (!diff || hit) ? '0 : cnt_q + CW'(1);
        db_d  = (diff && hit) ? ~db_q : db_q;
    end
    // Synchronizer, counter and debounced level all cleared by rst only
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], sig_raw};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end
    assign sig_db = db_q;
endmodule

// File: rtl/ctl_trigger.sv
// ctl_trigger: turns a bouncy trigger into one shot per pull with flash window, cooldown and dry-fire click
module ctl_trigger
    import ctl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int FLASH_CYCLES    = FLASH_CYCLES_DEF,
    parameter int COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic reset_score,
    input  logic trigger_raw,
    input  logic no_ammo,
    output logic shot_fired,
    output logic shot_flash,
    output logic click_empty,
    output logic trigger_ready
);
    localparam int TW = $clog2(max2(FLASH_CYCLES, COOLDOWN_CYCLES) + 1);
    trigger_state_t state_q;
    logic [TW-1:0]  timer_q;
    logic           shot_q, flash_q, click_q, ready_q;
    logic           db;
    ctl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk     (clk),
        .rst     (rst),
        .sig_raw (trigger_raw),
        .sig_db  (db)
    );
    // Trigger FSM with one shared down-counter; outputs are registered alongside the state they belong to
    always_ff @(posedge clk) begin
        if (rst || reset_score) begin
            state_q <= WAIT_RELEASE;
            timer_q <= '0;
            shot_q  <= 1'b0;
            flash_q <= 1'b0;
            click_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            shot_q  <= 1'b0;
            click_q <= 1'b0;
            case (state_q)
                WAIT_RELEASE: begin
                    if (!db) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (db) begin
                        ready_q <= 1'b0;
                        if (no_ammo) begin
                            state_q <= WAIT_RELEASE;
                            click_q <= 1'b1;
                        end else begin
                            state_q <= FLASH;
                            shot_q  <= 1'b1;
                            flash_q <= 1'b1;
                            timer_q <= TW'(FLASH_CYCLES - 1);
                        end
                    end
                end
                FLASH: begin
                    if (timer_q == '0) begin
                        state_q <= COOLDOWN;
                        flash_q <= 1'b0;
                        timer_q <= TW'(COOLDOWN_CYCLES - 1);
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                COOLDOWN: begin
                    if (timer_q == '0) state_q <= WAIT_RELEASE;
                    else timer_q <= timer_q - TW'(1);
                end
                default: state_q <= WAIT_RELEASE;
            endcase
        end
    end
    assign shot_fired    = shot_q;
    assign shot_flash    = flash_q;
    assign click_empty   = click_q;
    assign trigger_ready = ready_q;
endmodule

// File: tb/tb_ctl_trigger.sv
// tb_ctl_trigger: directed pulls with a scoreboard of expected shot/click events and flash lengths
module tb_ctl_trigger;
    localparam int DB = 4, FL = 3, CD = 8;
    typedef struct {
        int kind;
        int at;
        int flen;
    } ev_t;
    logic clk = 1'b0;
    logic rst, reset_score, trigger_raw, no_ammo;
    logic shot_fired, shot_flash, click_empty, trigger_ready;
    logic use_ammo, no_ammo_f, ammo_load;
    int   ammo = 16;
    int   cyc = 0;
    int   n_chk = 0, n_pass = 0;
    int   flen = 0, exp_flen = 0;
    logic flash_prev = 1'b0;
    ev_t  exp_q[$];
    ctl_trigger #(.DEBOUNCE_CYCLES(DB), .FLASH_CYCLES(FL), .COOLDOWN_CYCLES(CD)) dut (
        .clk           (clk),
        .rst           (rst),
        .reset_score   (reset_score),
        .trigger_raw   (trigger_raw),
        .no_ammo       (no_ammo),
        .shot_fired    (shot_fired),
        .shot_flash    (shot_flash),
        .click_empty   (click_empty),
        .trigger_ready (trigger_ready)
    );
    always #5 clk = ~clk;
    assign no_ammo = use_ammo ? (ammo == 0) : no_ammo_f;
    // Cycle counter used to time-stamp expected events
    always @(posedge clk) cyc <= cyc + 1;
    // Behavioural 16-round magazine standing in for the ammo counter
    always @(posedge clk) begin
        if (ammo_load) ammo <= 16;
        else if (shot_fired && ammo > 0) ammo <= ammo - 1;
    end
    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic expect_ev(input int kind, input int flen_req);
        ev_t e;
        e.kind = kind;
        e.at   = cyc + 7;
        e.flen = flen_req;
        exp_q.push_back(e);
    endtask
    task automatic pull(input int hold, input int kind, input int flen_req, input int rest);
        trigger_raw = 1'b1;
        if (kind >= 0) expect_ev(kind, flen_req);
        tick(hold);
        trigger_raw = 1'b0;
        tick(rest);
    endtask
    // Monitor: pop an expectation on every shot/click pulse and measure each flash run
    always @(negedge clk) begin : mon
        ev_t e;
        if (shot_fired || click_empty) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", int'({shot_fired, click_empty}), 0);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", shot_fired ? 0 : 1, e.kind);
                check("event_cycle", cyc, e.at);
                if (shot_fired) begin
                    check("flash_with_shot", int'(shot_flash), 1);
                    check("click_with_shot", int'(click_empty), 0);
                    exp_flen = e.flen;
                end else begin
                    check("flash_on_click", int'(shot_flash), 0);
                end
            end
        end
        if (shot_flash) flen++;
        else if (flash_prev) begin
            check("flash_len", flen, exp_flen);
            flen = 0;
        end
        flash_prev = shot_flash;
    end
    initial begin
        rst = 1'b1; reset_score = 1'b0; trigger_raw = 1'b0;
        no_ammo_f = 1'b0; use_ammo = 1'b0; ammo_load = 1'b1;
        tick(3);
        check("rst_shot_fired", int'(shot_fired), 0);
        check("rst_shot_flash", int'(shot_flash), 0);
        check("rst_click_empty", int'(click_empty), 0);
        check("rst_trigger_ready", int'(trigger_ready), 0);
        rst = 1'b0;
        tick(3);
        check("ready_after_rst", int'(trigger_ready), 1);
        // 1: clean held pull gives exactly one shot
        pull(20, 0, FL, 20);
        check("ready_after_t1", int'(trigger_ready), 1);
        // 2: short bounces are filtered, the stable run fires once
        for (int i = 0; i < 4; i++) begin
            trigger_raw = (i % 2 == 0);
            tick(2);
        end
        pull(20, 0, FL, 20);
        // 3: re-pull during cooldown is ignored, later pull fires
        trigger_raw = 1'b1;
        expect_ev(0, FL);
        tick(5);
        trigger_raw = 1'b0;
        tick(6);
        trigger_raw = 1'b1;
        tick(3);
        check("ready_in_cooldown", int'(trigger_ready), 0);
        tick(3);
        trigger_raw = 1'b0;
        tick(15);
        check("ready_after_cooldown", int'(trigger_ready), 1);
        pull(5, 0, FL, 25);
        // 4: empty magazine clicks once per pull
        no_ammo_f = 1'b1;
        pull(20, 1, 0, 20);
        no_ammo_f = 1'b0;
        check("ready_after_click", int'(trigger_ready), 1);
        // 5: reset_score in second flash cycle with trigger held
        trigger_raw = 1'b1;
        expect_ev(0, 2);
        tick(8);
        reset_score = 1'b1;
        tick(1);
        reset_score = 1'b0;
        check("rs_shot_flash", int'(shot_flash), 0);
        check("rs_shot_fired", int'(shot_fired), 0);
        check("rs_trigger_ready", int'(trigger_ready), 0);
        tick(11);
        trigger_raw = 1'b0;
        tick(20);
        pull(5, 0, FL, 25);
        // 6: 16-round magazine, 17th pull clicks
        use_ammo = 1'b1;
        ammo_load = 1'b0;
        for (int i = 0; i < 17; i++) pull(5, (i < 16) ? 0 : 1, FL, 25);
        check("ammo_left", ammo, 0);
        tick(10);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
